csr_trap_unit: RTL

CSR_TRAP_UNIT -- requirements
Module: csr_trap_unit

---
 rtl/csr_trap_unit.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and interrupt trap sequencer: 2-flop irq sync, combinational redirect, CSR/FSM updates at the clk edge.
// Redirect (epc_taken/epc) is same-cycle; no backpressure, blocked interrupts stay pending while their level is held.
module csr_trap_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_out,
    input  logic        br_taken,
    input  logic        j_en,
    input  logic        is_mret,
    input  logic        csr_we,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    input  logic        ext_irq,
    input  logic        timer_irq,
    output logic [31:0] epc,
    output logic        epc_taken
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MIP     = 12'h344;

    localparam logic [31:0] CAUSE_EXT   = 32'h8000_000B;
    localparam logic [31:0] CAUSE_TIMER = 32'h8000_0007;
    localparam logic [31:0] ALIGN_MASK  = 32'hFFFF_FFFC;

    typedef enum logic {
        RUN     = 1'b0,
        HANDLER = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic        mie_meie;
    logic        mie_mtie;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] mcause;

    logic [1:0]  ext_sync;
    logic [1:0]  tim_sync;
    logic        meip;
    logic        mtip;
    logic        ext_hit;
    logic        tim_hit;
    logic        take_irq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_sync <= 2'b00;
            tim_sync <= 2'b00;
        end else begin
            ext_sync <= {ext_sync[0], ext_irq};
            tim_sync <= {tim_sync[0], timer_irq};
        end
    end

    assign meip    = ext_sync[1];
    assign mtip    = tim_sync[1];
    assign ext_hit = meip & mie_meie;
    assign tim_hit = mtip & mie_mtie;

    // Any redirect, MRET or CSR write in flight defers the trap by a cycle.
    assign take_irq = (state == RUN) & mstatus_mie & (ext_hit | tim_hit)
                    & ~br_taken & ~j_en & ~is_mret & ~csr_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (take_irq) begin
            state_nxt = HANDLER;
        end else if (is_mret) begin
            state_nxt = RUN;
        end
    end

    always_comb begin
        epc_taken = 1'b0;
        epc       = mepc;
        if (take_irq) begin
            epc_taken = 1'b1;
            epc       = mtvec;
        end else if (is_mret) begin
            epc_taken = rst_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_meie     <= 1'b0;
            mie_mtie     <= 1'b0;
            mtvec        <= 32'h0;
            mepc         <= 32'h0;
            mcause       <= 32'h0;
        end else if (take_irq) begin
            mepc         <= (pc_out + 32'd4) & ALIGN_MASK;
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
            mcause       <= ext_hit ? CAUSE_EXT : CAUSE_TIMER;
        end else begin
            // MRET owns mstatus this cycle; other CSR writes still land.
            if (is_mret) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
            end else if (csr_we && csr_addr == ADDR_MSTATUS) begin
                mstatus_mie  <= csr_wdata[3];
                mstatus_mpie <= csr_wdata[7];
            end
            if (csr_we) begin
                case (csr_addr)
                    ADDR_MIE: begin
                        mie_mtie <= csr_wdata[7];
                        mie_meie <= csr_wdata[11];
                    end
                    ADDR_MTVEC:  mtvec  <= csr_wdata & ALIGN_MASK;
                    ADDR_MEPC:   mepc   <= csr_wdata & ALIGN_MASK;
                    ADDR_MCAUSE: mcause <= csr_wdata;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        csr_rdata = 32'h0;
        case (csr_addr)
            ADDR_MSTATUS: begin
                csr_rdata[3] = mstatus_mie;
                csr_rdata[7] = mstatus_mpie;
            end
            ADDR_MIE: begin
                csr_rdata[7]  = mie_mtie;
                csr_rdata[11] = mie_meie;
            end
            ADDR_MTVEC:  csr_rdata = mtvec;
            ADDR_MEPC:   csr_rdata = mepc;
            ADDR_MCAUSE: csr_rdata = mcause;
            ADDR_MIP: begin
                csr_rdata[7]  = mtip;
                csr_rdata[11] = meip;
            end
            default: csr_rdata = 32'h0;
        endcase
    end

endmodule
